sad7_min_tracker: RTL
=====================

Name: sad7_min_tracker

Overview:
- Stage-7 consumer of the SAD6→SAD7 pipeline register.
- Each cycle of a search window it takes the two stage-6 partial minima (A/B index+value pairs) and folds them into a running global minimum.
- When the window's final pair arrives (TriggerBoss), it registers the winning index/value and the candidate count, then holds them under a Done/Ack handshake for the top-level controller.

Parameters:
IDX_W, 16, width of candidate index
VAL_W, 14, width of SAD value
CNT_W, 16, width of candidate-pair counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
Start  in  1  search-window start pulse from controller
SAD7_TriggerBoss  in  1  current A/B pair is the last of the window
SAD7_IndexOfMinA  in  IDX_W  index of lane-A minimum
SAD7_ValueOfMinA  in  VAL_W  SAD value of lane-A minimum
SAD7_IndexOfMinB  in  IDX_W  index of lane-B minimum
SAD7_ValueOfMinB  in  VAL_W  SAD value of lane-B minimum
ResultAck  in  1  controller has consumed result
Busy  out  1  high in SEARCH
Done  out  1  result valid, held until ResultAck
BestIndex  out  IDX_W  index of global minimum
BestValue  out  VAL_W  global minimum SAD value
PairCount  out  CNT_W  pairs folded in this window, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE; Busy=0, Done=0, BestIndex=0, BestValue=0, PairCount=0; internal running min and first-flag cleared.
- States: IDLE, SEARCH, DONE. All transitions occur on the rising edge of clk.
- IDLE:
  - Start=1 → SEARCH; first-flag=1; counter=0.
  - Candidate inputs are not sampled in the Start cycle.
  - TriggerBoss is ignored in IDLE.
- SEARCH (Busy=1), every cycle:
  - Pair winner: A if ValueA <= ValueB, else B (A wins ties).
  - If first-flag, the running min loads the pair winner unconditionally and first-flag clears.
  - Otherwise the running min is replaced only if winner value < running value (strict; the earlier candidate wins ties).
  - Counter increments, saturating at 2^CNT_W−1.
  - Start is ignored in SEARCH.
- SEARCH with TriggerBoss=1:
  - The current pair is folded in as above.
  - The final min (including this pair) and the counter (including this pair) are registered into BestIndex, BestValue and PairCount.
  - Next state DONE.
  - Latency: Done=1 on the first edge after the trigger-pair edge, i.e. visible one cycle after TriggerBoss is sampled.
  - A single-pair window (TriggerBoss on the first SEARCH cycle) gives PairCount=1.
- DONE (Done=1, Busy=0):
  - Outputs are held stable.
  - ResultAck=1 → IDLE; Done drops the next cycle. BestIndex, BestValue and PairCount keep their values until the next window completes.
  - Start and TriggerBoss are ignored in DONE; Start in the same cycle as ResultAck is also ignored, so the controller must re-issue Start from IDLE.
  - ResultAck outside DONE has no effect.
- Arithmetic: unsigned magnitude compares only; no arithmetic widening. Value 2^VAL_W−1 is a legal candidate and is handled by the first-flag load, so there is no sentinel.
- Reset mid-SEARCH or mid-DONE: immediate return to IDLE; the partial result is discarded and outputs are zeroed.

Decomposition:
- Shared package (sad_pkg):
  - IDX_W, VAL_W and CNT_W constants.
  - State enum {IDLE, SEARCH, DONE}.
  - A candidate struct {index, value} reused by SAD6 and SAD7.
- One natural sub-module: sad_min2. It is purely combinational: it takes two candidates and returns the smaller, with the tie going to the first operand. It is instantiated twice: A vs B, then winner vs running min. The first-flag load bypasses the second compare.
- The FSM, counter and output registers live in the top module.

Test Plan:
- Reset then Start; 3 pairs (A=5/100, B=6/90), (A=7/95, B=8/200), (A=9/80, B=10/80 with TriggerBoss) → Done one cycle later; BestIndex=9, BestValue=80, PairCount=3.
- Tie handling: pair1 A=1/50, B=2/50; pair2 A=3/50, B=4/60 with TriggerBoss → BestIndex=1, BestValue=50 (A beats B, earlier beats later).
- Max-value window: single pair A=11/16383, B=12/16383 with TriggerBoss on the first SEARCH cycle → BestIndex=11, BestValue=16383, PairCount=1.
- Handshake: hold ResultAck=0 for 10 cycles in DONE while toggling Start and TriggerBoss → outputs unchanged and Done stays 1. Then pulse ResultAck → IDLE; Start accepted on the next cycle.
- Async reset asserted mid-SEARCH, between clock edges → Busy=0, Done=0, outputs 0 immediately, without waiting for an edge. A new window afterward gives correct results, with no stale minimum carried over.
- Saturation, using CNT_W=4 override: 20-pair window → PairCount=15.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared SAD pipeline types: widths, stage-7 FSM states and the index/value
// candidate record passed between SAD6 and SAD7.
package sad_pkg;

  localparam int IDX_W = 16;
  localparam int VAL_W = 14;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [VAL_W-1:0] value;
  } cand_t;

endpackage

// File: rtl/sad_min2.sv
// Two-way candidate minimum; ties resolve to the first operand so that
// lane A beats lane B and an older running minimum beats a newer one.
module sad_min2 #(
  parameter type candT = sad_pkg::cand_t
) (
  input  candT first,
  input  candT second,
  output candT smaller
);

  assign smaller = (second.value < first.value) ? second : first;

endmodule

// File: rtl/sad7_min_tracker.sv
// SAD stage 7: folds the per-cycle A/B partial minima into a window-wide
// minimum and presents the winner under a Done/ResultAck handshake.
module sad7_min_tracker import sad_pkg::*; #(
  parameter int IDX_W = sad_pkg::IDX_W,
  parameter int VAL_W = sad_pkg::VAL_W,
  parameter int CNT_W = sad_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             SAD7_TriggerBoss,
  input  logic [IDX_W-1:0] SAD7_IndexOfMinA,
  input  logic [VAL_W-1:0] SAD7_ValueOfMinA,
  input  logic [IDX_W-1:0] SAD7_IndexOfMinB,
  input  logic [VAL_W-1:0] SAD7_ValueOfMinB,
  input  logic             ResultAck,
  output logic             Busy,
  output logic             Done,
  output logic [IDX_W-1:0] BestIndex,
  output logic [VAL_W-1:0] BestValue,
  output logic [CNT_W-1:0] PairCount
);

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [VAL_W-1:0] value;
  } candP_t;

  state_t           state;
  logic             firstFlag;
  candP_t           runMin;
  candP_t           candA;
  candP_t           candB;
  candP_t           pairWin;
  candP_t           foldWin;
  candP_t           nextMin;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  assign candA = '{index: SAD7_IndexOfMinA, value: SAD7_ValueOfMinA};
  assign candB = '{index: SAD7_IndexOfMinB, value: SAD7_ValueOfMinB};

  sad_min2 #(.candT(candP_t)) uPair (
    .first  (candA),
    .second (candB),
    .smaller(pairWin)
  );

  // Running minimum goes first so an equal later value never displaces it.
  sad_min2 #(.candT(candP_t)) uFold (
    .first  (runMin),
    .second (pairWin),
    .smaller(foldWin)
  );

  // First pair loads unconditionally: no sentinel, so the max value is legal.
  assign nextMin = firstFlag ? pairWin : foldWin;
  assign cntNext = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      firstFlag <= 1'b0;
      runMin    <= '0;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      BestIndex <= '0;
      BestValue <= '0;
      PairCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state     <= SEARCH;
            firstFlag <= 1'b1;
            cnt       <= '0;
            Busy      <= 1'b1;
          end
        end
        SEARCH: begin
          runMin    <= nextMin;
          firstFlag <= 1'b0;
          cnt       <= cntNext;
          if (SAD7_TriggerBoss) begin
            BestIndex <= nextMin.index;
            BestValue <= nextMin.value;
            PairCount <= cntNext;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (ResultAck) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
